// File: rtl/imm_ext_pkg.sv
// Shared encodings and widths for the immediate-extension unit.
package imm_ext_pkg;

  localparam int unsigned ModeW   = 3;
  localparam int unsigned ErrCntW = 8;

  typedef logic [ModeW-1:0] mode_t;

  localparam mode_t MODE_ZERO   = 3'd0;
  localparam mode_t MODE_SIGN   = 3'd1;
  localparam mode_t MODE_UPPER  = 3'd2;
  localparam mode_t MODE_BRANCH = 3'd3;
  localparam mode_t MODE_BYTE   = 3'd4;

endpackage

// File: rtl/ext_fifo.sv
// Generic circular-buffer FIFO with synchronous flush; head is read straight from storage.
module ext_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [Width-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [Width-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == CntW'(Depth));
  assign o_empty   = (r_count == '0);
  assign w_wr      = i_wr_en && !o_full && !i_flush;
  assign w_rd      = i_rd_en && !o_empty && !i_flush;
  assign o_rd_data = r_mem[r_rptr];

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (w_wr) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/imm_ext_unit.sv
// Immediate extension (zero/sign/upper/branch/byte) feeding a result FIFO, with a
// saturating illegal-mode counter.
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_imm,
  input  logic [ModeW-1:0]   in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_err,
  output logic [ErrCntW-1:0] err_count
);

  // Packed as {err, data}.
  function automatic logic [OUT_W:0] extend(input logic [IN_W-1:0] imm, input mode_t mode);
    logic [OUT_W-1:0] sext;
    sext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    extend = '0;
    case (mode)
      MODE_ZERO:   extend = {1'b0, {(OUT_W-IN_W){1'b0}}, imm};
      MODE_SIGN:   extend = {1'b0, sext};
      MODE_UPPER:  extend = {1'b0, imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: extend = {1'b0, sext << BR_SHIFT};
      MODE_BYTE:   extend = {1'b0, {(OUT_W-8){imm[7]}}, imm[7:0]};
      default:     extend = {1'b1, {OUT_W{1'b0}}};
    endcase
  endfunction

  logic [OUT_W:0]     w_ext;
  logic [OUT_W:0]     w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_pop;
  logic [ErrCntW-1:0] r_err_count;

  assign w_ext     = extend(in_imm, in_mode);
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign {out_err, out_data} = w_head;
  assign err_count = r_err_count;

  ext_fifo #(
    .Width (OUT_W + 1),
    .Depth (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (flush),
    .i_wr_en   (w_accept),
    .i_wr_data (w_ext),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_accept && w_ext[OUT_W] && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed bench for imm_ext_unit: mode sweep, illegal modes, backpressure, wrap,
// async reset, flush and an IN_W=15 variant.
module tb_imm_ext_unit;
  import imm_ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  mode_t       in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [7:0]  err_count;

  logic        v_flush;
  logic        v_in_valid;
  logic        v_in_ready;
  logic [14:0] v_in_imm;
  mode_t       v_in_mode;
  logic        v_out_valid;
  logic        v_out_ready;
  logic [31:0] v_out_data;
  logic        v_out_err;
  logic [7:0]  v_err_count;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  imm_ext_unit u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_count (err_count)
  );

  imm_ext_unit #(
    .IN_W  (15),
    .OUT_W (32)
  ) u_dut15 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (v_flush),
    .in_valid  (v_in_valid),
    .in_ready  (v_in_ready),
    .in_imm    (v_in_imm),
    .in_mode   (v_in_mode),
    .out_valid (v_out_valid),
    .out_ready (v_out_ready),
    .out_data  (v_out_data),
    .out_err   (v_out_err),
    .err_count (v_err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input mode_t mode);
    in_valid = v;
    in_imm   = imm;
    in_mode  = mode;
  endtask

  initial begin
    flush = 0; in_valid = 0; in_imm = '0; in_mode = '0; out_ready = 0;
    v_flush = 0; v_in_valid = 0; v_in_imm = '0; v_in_mode = '0; v_out_ready = 0;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Mode sweep; each result is the head one cycle after its accept
    out_ready = 1;
    drive(1, 16'h8001, MODE_ZERO);   cyc();
    check("zero_valid", 32'(out_valid), 32'd1);
    check("zero_data", out_data, 32'h00008001);
    check("zero_err", 32'(out_err), 32'd0);
    drive(1, 16'h8001, MODE_SIGN);   cyc();
    check("sign_data", out_data, 32'hFFFF8001);
    drive(1, 16'h8001, MODE_UPPER);  cyc();
    check("upper_data", out_data, 32'h80010000);
    drive(1, 16'hFFFF, MODE_BRANCH); cyc();
    check("branch_data", out_data, 32'hFFFFFFFC);
    drive(1, 16'h1280, MODE_BYTE);   cyc();
    check("byte_data", out_data, 32'hFFFFFF80);
    check("byte_err", 32'(out_err), 32'd0);

    // Illegal modes
    drive(1, 16'h8001, 3'd5); cyc();
    check("ill5_data", out_data, 32'd0);
    check("ill5_err", 32'(out_err), 32'd1);
    check("ill5_cnt", 32'(err_count), 32'd1);
    drive(1, 16'h8001, 3'd6); cyc();
    check("ill6_data", out_data, 32'd0);
    check("ill6_err", 32'(out_err), 32'd1);
    drive(1, 16'h8001, 3'd7); cyc();
    check("ill7_err", 32'(out_err), 32'd1);
    check("ill7_cnt", 32'(err_count), 32'd3);

    // Saturation: 256 more illegal accepts
    drive(1, 16'h0000, 3'd5);
    repeat (251) cyc();
    check("sat_254", 32'(err_count), 32'd254);
    repeat (5) cyc();
    drive(0, 16'h0000, MODE_ZERO);
    cyc();
    check("sat_255", 32'(err_count), 32'd255);
    check("sat_empty", 32'(out_valid), 32'd0);

    // Backpressure: 6 requests offered, 4 accepted
    out_ready = 0;
    drive(1, 16'd1, MODE_ZERO); cyc();
    drive(1, 16'd2, MODE_ZERO); cyc();
    drive(1, 16'd3, MODE_ZERO); cyc();
    check("bp_ready_3", 32'(in_ready), 32'd1);
    drive(1, 16'd4, MODE_ZERO); cyc();
    check("bp_ready_4", 32'(in_ready), 32'd0);
    drive(1, 16'd5, MODE_ZERO); cyc();
    drive(1, 16'd6, MODE_ZERO); cyc();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_head_1", out_data, 32'd1);
    drive(1, 16'd5, MODE_ZERO);
    out_ready = 1;
    cyc();
    check("bp_head_2", out_data, 32'd2);
    check("bp_ready_pop", 32'(in_ready), 32'd1);
    cyc();
    drive(0, 16'd0, MODE_ZERO);
    check("bp_head_3", out_data, 32'd3);
    cyc();
    check("bp_head_4", out_data, 32'd4);
    cyc();
    check("bp_head_5", out_data, 32'd5);
    cyc();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Simultaneous accept and pop at occupancy 2, wrapping the pointers
    out_ready = 0;
    drive(1, 16'h0100, MODE_ZERO); cyc();
    drive(1, 16'h0101, MODE_ZERO); cyc();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'(16'h0102 + i), MODE_ZERO);
      check("sim_head", out_data, 32'(32'h0100 + i));
      check("sim_ready", 32'(in_ready), 32'd1);
      cyc();
    end
    drive(0, 16'd0, MODE_ZERO);
    check("sim_tail_a", out_data, 32'h010A);
    cyc();
    check("sim_tail_b", out_data, 32'h010B);
    check("sim_tail_valid", 32'(out_valid), 32'd1);
    cyc();
    check("sim_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-cycle with entries queued
    out_ready = 0;
    drive(1, 16'h0055, MODE_ZERO); cyc(); cyc();
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    check("ar_err_count", 32'(err_count), 32'd0);
    check("ar_out_data", out_data, 32'd0);
    check("ar_out_err", 32'(out_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 16'h8001, MODE_SIGN);
    cyc();
    check("ar_first_valid", 32'(out_valid), 32'd1);
    check("ar_first_data", out_data, 32'hFFFF8001);
    drive(0, 16'd0, MODE_ZERO);
    out_ready = 1;
    cyc();
    check("ar_drained", 32'(out_valid), 32'd0);

    // Flush with 3 queued, concurrent accept and pop discarded
    out_ready = 0;
    drive(1, 16'h0000, 3'd5);
    repeat (3) cyc();
    check("fl_pre_cnt", 32'(err_count), 32'd3);
    flush = 1;
    out_ready = 1;
    cyc();
    flush = 0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_err_count", 32'(err_count), 32'd3);
    drive(1, 16'h1234, MODE_ZERO);
    cyc();
    check("fl_after_data", out_data, 32'h00001234);
    check("fl_after_err", 32'(out_err), 32'd0);
    drive(0, 16'd0, MODE_ZERO);
    cyc();

    // IN_W = 15 variant
    v_in_valid = 1; v_in_imm = 15'h4000; v_in_mode = MODE_SIGN; v_out_ready = 1;
    cyc();
    v_in_valid = 0;
    check("w15_valid", 32'(v_out_valid), 32'd1);
    check("w15_data", v_out_data, 32'hFFFFC000);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
